// File: rtl/carry_select_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder/subtractor.
// Optional flag outputs are controlled by the CSA_FLAGS_EN macro in the top.
package carry_select_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of carry-select blocks, which is also the pipeline depth.
    function automatic int nblk(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: both carry-in hypotheses are summed in parallel and
// the incoming carry only drives the final 2:1 select.
module csel_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK:0] sum_c0;
    logic [BLK:0] sum_c1;

    always_comb begin
        sum_c0 = {1'b0, a} + {1'b0, b};
        sum_c1 = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);
        {cout, sum} = cin ? sum_c1 : sum_c0;
    end

endmodule

// File: rtl/carry_select_pipe.sv
// Pipelined carry-select adder/subtractor, one BLK-bit block resolved per stage,
// valid/ready on both sides. Define CSA_FLAGS_EN to add out_ovf/out_zero.
module carry_select_pipe
    import carry_select_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CSA_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero
`endif
);

    localparam int NBLK = nblk(WIDTH, BLK);
    localparam int LAST = NBLK - 1;

    if ((BLK < 1) || (WIDTH < BLK) || ((WIDTH % BLK) != 0)) begin : g_bad_cfg
        $error("carry_select_pipe: WIDTH must be a non-zero multiple of BLK");
    end

    // Per stage: skewed operands, partially resolved sum, carry into next block.
    logic [NBLK-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [NBLK-1:0]            c_q, c_d, v_q, v_d;

    logic [NBLK-1:0][WIDTH-1:0] src_a, src_b, src_s;
    logic [NBLK-1:0]            src_c, src_v;
    logic [NBLK-1:0][BLK-1:0]   blk_sum;
    logic [NBLK-1:0]            blk_cout;
    logic                       adv;

    assign adv       = !v_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign out_sum   = s_q[LAST];
    assign out_cout  = c_q[LAST];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        src_a = '0;
        src_b = '0;
        src_s = '0;
        src_c = '0;
        src_v = '0;
        src_a[0] = in_a;
        src_b[0] = (in_sub == OP_SUB) ? ~in_b : in_b;
        src_c[0] = (in_sub == OP_SUB) ? 1'b1 : in_cin;
        src_v[0] = in_valid;
        for (int k = 1; k < NBLK; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_v[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csel_block #(.BLK(BLK)) u_blk (
            .a    (src_a[k][k*BLK +: BLK]),
            .b    (src_b[k][k*BLK +: BLK]),
            .cin  (src_c[k]),
            .sum  (blk_sum[k]),
            .cout (blk_cout[k])
        );
    end

    always_comb begin
        a_d = src_a;
        b_d = src_b;
        s_d = src_s;
        c_d = blk_cout;
        v_d = src_v;
        for (int k = 0; k < NBLK; k++) begin
            s_d[k][k*BLK +: BLK] = blk_sum[k];
        end
    end

    // NOTE: non-blocking assignments for all state so every stage samples the
    // previous stage's pre-edge value; data regs are reset too so out_sum reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= '0;
            v_q <= '0;
        end else if (adv) begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

`ifdef CSA_FLAGS_EN
    logic ovf_q, ovf_d, zero_q, zero_d;

    // The operand MSBs ride along untouched, so the last stage still sees a and b'.
    always_comb begin
        ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                 (s_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
        zero_d = (s_d[LAST] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_carry_select_pipe.sv
// Self-checking bench: 16/4 pipeline with a queue scoreboard, plus an 8/8 (single stage) instance.
module tb_carry_select_pipe;

    localparam int W  = 16;
    localparam int B  = 4;
    localparam int NB = W / B;
    localparam int W1 = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready, out_cout;
    logic [W-1:0]  out_sum;
    logic          out_ovf, out_zero;

    logic          t_in_valid, t_in_ready, t_in_cin, t_in_sub;
    logic [W1-1:0] t_in_a, t_in_b;
    logic          t_out_valid, t_out_ready, t_out_cout;
    logic [W1-1:0] t_out_sum;
    logic          t_out_ovf, t_out_zero;

    int n_checks = 0;
    int n_fail   = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    carry_select_pipe #(.WIDTH(W), .BLK(B)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
`ifdef CSA_FLAGS_EN
        , .out_ovf(out_ovf), .out_zero(out_zero)
`endif
    );

    carry_select_pipe #(.WIDTH(W1), .BLK(W1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_a(t_in_a), .in_b(t_in_b), .in_cin(t_in_cin), .in_sub(t_in_sub),
        .out_valid(t_out_valid), .out_ready(t_out_ready),
        .out_sum(t_out_sum), .out_cout(t_out_cout)
`ifdef CSA_FLAGS_EN
        , .out_ovf(t_out_ovf), .out_zero(t_out_zero)
`endif
    );

`ifndef CSA_FLAGS_EN
    assign out_ovf    = 1'b0;
    assign out_zero   = 1'b0;
    assign t_out_ovf  = 1'b0;
    assign t_out_zero = 1'b0;
`endif

    // Reference arithmetic on plain integers: true modular result, unsigned
    // carry/no-borrow, and signed overflow as an out-of-range signed result.
    function automatic void ref_calc(input int w, input longint unsigned a, input longint unsigned b,
                                     input bit cin, input bit sub, output longint unsigned sum,
                                     output bit cout, output bit ovf, output bit zero);
        longint unsigned m;
        longint sa, sb, sr;
        m  = 64'd1 << w;
        sa = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
        sb = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
        if (sub) begin
            sum  = (a - b) % m;
            cout = (a >= b);
            sr   = sa - sb;
        end else begin
            sum  = (a + b + 64'(cin)) % m;
            cout = ((a + b + 64'(cin)) >= m);
            sr   = sa + sb + longint'(cin);
        end
        ovf  = (sr >= longint'(m / 2)) || (sr < -longint'(m / 2));
        zero = (sum == 0);
    endfunction

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        longint unsigned s;
        bit co, ov, z;
        res_t r;
        ref_calc(W, 64'(a), 64'(b), cin, sub, s, co, ov, z);
        r.sum  = W'(s);
        r.cout = co;
`ifdef CSA_FLAGS_EN
        r.ovf  = ov;
        r.zero = z;
`else
        r.ovf  = 1'b0;
        r.zero = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom % 5)
            0: return '1;
            1: return '0;
            2: return W'(1) << (W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    // One clock of the 16/4 DUT: drive after the falling edge, observe 1 ns later,
    // and update the scoreboard with what the coming rising edge will transfer.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic ordy,
                         output logic acc, output logic popped, output res_t got,
                         output res_t exp, output logic empty);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = c;
        in_sub    = s;
        out_ready = ordy;
        #1;
        acc      = in_valid && in_ready;
        popped   = out_valid && out_ready;
        got.sum  = out_sum;
        got.cout = out_cout;
        got.ovf  = out_ovf;
        got.zero = out_zero;
        empty    = popped && (exp_q.size() == 0);
        exp      = '0;
        if (popped && !empty) exp = exp_q.pop_front();
        if (acc) exp_q.push_back(model(a, b, c, s));
    endtask

    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic s, output res_t got, output int lat);
        logic acc, p, e;
        res_t g, x;
        cycle(1'b1, a, b, c, s, 1'b1, acc, p, g, x, e);
        lat = 0;
        got = '0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, p, g, x, e);
            lat++;
            if (p) begin
                got = g;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        t_in_valid = 1'b0; t_in_a = '0; t_in_b = '0; t_in_cin = 1'b0; t_in_sub = 1'b0;
        t_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
        if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got=%b exp=0", out_cout); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        res_t g;
        int lat;
        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, g, lat);
        n_checks += 3;
        if (lat != NB) begin n_fail++; $display("FAIL latency got=%0d exp=%0d", lat, NB); end
        if (g.sum !== 16'h0000) begin n_fail++; $display("FAIL add_ffff_1_sum got=%h exp=0000", g.sum); end
        if (g.cout !== 1'b1) begin n_fail++; $display("FAIL add_ffff_1_cout got=%b exp=1", g.cout); end

        send_one(16'h0005, 16'h0007, 1'b1, 1'b1, g, lat);
        n_checks += 2;
        if (g.sum !== 16'hFFFE) begin n_fail++; $display("FAIL sub_5_7_sum got=%h exp=fffe", g.sum); end
        if (g.cout !== 1'b0) begin n_fail++; $display("FAIL sub_5_7_cout got=%b exp=0", g.cout); end

        send_one(16'h0007, 16'h0005, 1'b0, 1'b1, g, lat);
        n_checks += 2;
        if (g.sum !== 16'h0002) begin n_fail++; $display("FAIL sub_7_5_sum got=%h exp=0002", g.sum); end
        if (g.cout !== 1'b1) begin n_fail++; $display("FAIL sub_7_5_cout got=%b exp=1", g.cout); end

        send_one(16'h00FF, 16'h0000, 1'b1, 1'b0, g, lat);
        n_checks += 2;
        if (g.sum !== 16'h0100) begin n_fail++; $display("FAIL add_cin_sum got=%h exp=0100", g.sum); end
        if (g.cout !== 1'b0) begin n_fail++; $display("FAIL add_cin_cout got=%b exp=0", g.cout); end

`ifdef CSA_FLAGS_EN
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, g, lat);
        n_checks += 2;
        if (g.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_7fff_ovf got=%b exp=1", g.ovf); end
        if (g.zero !== 1'b0) begin n_fail++; $display("FAIL ovf_7fff_zero got=%b exp=0", g.zero); end
        send_one(16'h1234, 16'h1234, 1'b0, 1'b1, g, lat);
        n_checks += 2;
        if (g.zero !== 1'b1) begin n_fail++; $display("FAIL zero_1234_zero got=%b exp=1", g.zero); end
        if (g.ovf !== 1'b0) begin n_fail++; $display("FAIL zero_1234_ovf got=%b exp=0", g.ovf); end
`endif
    endtask

    task automatic test_back_to_back();
        logic acc, p, e;
        res_t g, x;
        int n_pop = 0, first = -1, last = -1;
        for (int i = 0; i < 8 + NB + 3; i++) begin
            cycle(i < 8, pick(), pick(), 1'($urandom), 1'($urandom), 1'b1, acc, p, g, x, e);
            if (i < 8) begin
                n_checks++;
                if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=1", i, acc); end
            end
            if (p) begin
                n_checks++;
                if (e || g !== x) begin n_fail++; $display("FAIL b2b_result got=%h exp=%h empty=%b", g, x, e); end
                n_pop++;
                if (first < 0) first = i;
                last = i;
            end
        end
        n_checks += 2;
        if (n_pop != 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", n_pop); end
        if (last - first != 7) begin n_fail++; $display("FAIL b2b_contiguous got=%0d exp=7", last - first); end
    endtask

    task automatic fill_stalled();
        logic acc, p, e;
        res_t g, x;
        for (int i = 0; i < NB; i++) begin
            cycle(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b0, acc, p, g, x, e);
            n_checks++;
            if (acc !== 1'b1) begin n_fail++; $display("FAIL fill_accept beat=%0d got=%b exp=1", i, acc); end
        end
    endtask

    task automatic test_stall();
        logic acc, p, e;
        res_t g, x;
        logic [W-1:0] xa, xb;
        int n_pop = 0, pop_at[$];
        xa = pick();
        xb = pick();
        fill_stalled();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, xa, xb, 1'b0, 1'b1, 1'b0, acc, p, g, x, e);
            n_checks += 3;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got=%b exp=1", out_valid); end
            if (out_sum !== exp_q[0].sum) begin n_fail++; $display("FAIL stall_out_sum got=%h exp=%h", out_sum, exp_q[0].sum); end
        end
        for (int i = 0; i < 3 * NB; i++) begin
            cycle(i == 0, xa, xb, 1'b0, 1'b1, 1'b1, acc, p, g, x, e);
            if (p) begin
                n_checks++;
                if (e || g !== x) begin n_fail++; $display("FAIL stall_result got=%h exp=%h empty=%b", g, x, e); end
                n_pop++;
                pop_at.push_back(i);
            end
        end
        n_checks += 2;
        if (n_pop != NB + 1) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", n_pop, NB + 1); end
        if (n_pop < NB || pop_at[NB-1] != NB - 1) begin
            n_fail++; $display("FAIL stall_drain_contiguous pops=%0d exp_first_%0d_back_to_back", n_pop, NB);
        end
    endtask

    task automatic test_flush();
        logic acc, p, e;
        res_t g, x;
        int n_pop = 0;
        fill_stalled();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, p, g, x, e);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid got=%b exp=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_async_valid got=%b exp=0", out_valid); end
        if (out_sum !== '0) begin n_fail++; $display("FAIL flush_async_sum got=%h exp=0", out_sum); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3 * NB; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, p, g, x, e);
            if (p) n_pop++;
        end
        n_checks++;
        if (n_pop != 0) begin n_fail++; $display("FAIL flush_emitted got=%0d exp=0", n_pop); end
    endtask

    task automatic test_nblk1();
        longint unsigned s;
        bit co, ov, z;
        logic [W1-1:0] e_sum;
        logic e_cout, e_ovf, e_zero;
        e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0; e_zero = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            t_in_valid  = 1'b1;
            t_in_a      = W1'($urandom);
            t_in_b      = (i % 7 == 3) ? t_in_a : W1'($urandom);
            t_in_cin    = 1'($urandom);
            t_in_sub    = 1'($urandom);
            t_out_ready = 1'b1;
            #1;
            n_checks++;
            if (t_out_valid !== (i > 0)) begin n_fail++; $display("FAIL nblk1_valid i=%0d got=%b exp=%b", i, t_out_valid, i > 0); end
            if (i > 0) begin
                n_checks += 2;
                if (t_out_sum !== e_sum) begin n_fail++; $display("FAIL nblk1_sum got=%h exp=%h", t_out_sum, e_sum); end
                if (t_out_cout !== e_cout) begin n_fail++; $display("FAIL nblk1_cout got=%b exp=%b", t_out_cout, e_cout); end
`ifdef CSA_FLAGS_EN
                n_checks += 2;
                if (t_out_ovf !== e_ovf) begin n_fail++; $display("FAIL nblk1_ovf got=%b exp=%b", t_out_ovf, e_ovf); end
                if (t_out_zero !== e_zero) begin n_fail++; $display("FAIL nblk1_zero got=%b exp=%b", t_out_zero, e_zero); end
`endif
            end
            ref_calc(W1, 64'(t_in_a), 64'(t_in_b), t_in_cin, t_in_sub, s, co, ov, z);
            e_sum = W1'(s); e_cout = co; e_ovf = ov; e_zero = z;
        end
        @(negedge clk);
        t_in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic acc, p, e;
        res_t g, x;
        logic cv, cc, cs;
        logic [W-1:0] ca, cb;
        cv = 1'b0; cc = 1'b0; cs = 1'b0; ca = '0; cb = '0; acc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!cv || acc) begin
                cv = ($urandom % 4) != 0;
                ca = pick();
                cb = ($urandom % 10 == 0) ? ca : pick();
                cc = 1'($urandom);
                cs = 1'($urandom);
            end
            cycle(cv, ca, cb, cc, cs, ($urandom % 3) != 0, acc, p, g, x, e);
            if (p) begin
                n_checks++;
                if (e || g !== x) begin n_fail++; $display("FAIL random_result got=%h exp=%h empty=%b", g, x, e); end
            end
        end
        for (int i = 0; i < 3 * NB; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, p, g, x, e);
            if (p) begin
                n_checks++;
                if (e || g !== x) begin n_fail++; $display("FAIL random_drain got=%h exp=%h empty=%b", g, x, e); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_flush();
        test_nblk1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
